// File: rtl/toggle_edge_tracker.sv
// Per-bit rise/fall detector with a sticky coverage mask and covered-event count.
// Optional build macro TOGGLE_FIRST_HIT_EN: report each event only on its first hit since reset/clear.
module toggle_edge_tracker #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic [WIDTH-1:0]     sig,
  input  logic                 clear,
  output logic [2*WIDTH-1:0]   valid,
  output logic [CNT_W-1:0]     covered_cnt,
  output logic                 all_covered
);

  typedef enum logic {INIT, TRACK} state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   prev_reg;
  logic [2*WIDTH-1:0] seen_reg;

  logic               sample_live;
  logic [WIDTH-1:0]   rise;
  logic [WIDTH-1:0]   fall;
  logic [2*WIDTH-1:0] hits;
  logic [2*WIDTH-1:0] seen_base;
  logic [2*WIDTH-1:0] seen_next;
  logic [2*WIDTH-1:0] report_next;
  logic [CNT_W-1:0]   cnt_next;
  logic               all_next;

  // Edges only count once a priming sample exists and the current cycle is enabled.
  assign sample_live = en && (state_reg == TRACK);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
      assign rise[gi] = sample_live & ~prev_reg[gi] &  sig[gi];
      assign fall[gi] = sample_live &  prev_reg[gi] & ~sig[gi];
    end
  endgenerate

  assign hits      = {fall, rise};
  assign seen_base = clear ? '0 : seen_reg;
  assign seen_next = seen_base | hits;

`ifdef TOGGLE_FIRST_HIT_EN
  assign report_next = hits & ~seen_base;
`else
  assign report_next = hits;
`endif

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < 2*WIDTH; i++) begin
      cnt_next = cnt_next + CNT_W'(seen_next[i]);
    end
  end

  assign all_next = (cnt_next == CNT_W'(2*WIDTH));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= INIT;
      prev_reg    <= '0;
      seen_reg    <= '0;
      valid       <= '0;
      covered_cnt <= '0;
      all_covered <= 1'b0;
    end else begin
      case (state_reg)
        INIT: begin
          if (en) begin
            prev_reg  <= sig;
            state_reg <= TRACK;
          end
        end
        TRACK: begin
          if (en) begin
            prev_reg <= sig;
          end
        end
        default: state_reg <= INIT;
      endcase
      seen_reg    <= seen_next;
      valid       <= report_next;
      covered_cnt <= cnt_next;
      all_covered <= all_next;
    end
  end

endmodule

// File: doc/toggle_edge_tracker.md
# toggle_edge_tracker

Per-bit toggle detector placed directly upstream of the 32-bit toggle-coverage reporter. It samples a WIDTH-bit observed signal and produces a registered 2*WIDTH-bit `valid` vector: one bit per rise and one per fall. That vector connects unchanged to the reporter's `valid` input. It also keeps a sticky per-event coverage mask and a covered-event count for the fuzzing loop.

## Interface
- `WIDTH`, default 16: number of observed signal bits. The output vector is 2*WIDTH bits, which is 32 at the default.
- `CNT_W`, default 6: counter width. Must satisfy 2^CNT_W > 2*WIDTH.

Ports:
- `clock`  in  1  sole clock; all state updates on its posedge.
- `reset`  in  1  synchronous, active-high.
- `en`  in  1  sample enable; when low, the block holds and reports nothing.
- `sig`  in  WIDTH  observed signal.
- `clear`  in  1  clears the sticky coverage mask and count.
- `valid`  out  2*WIDTH  per-cycle event pulses. Bit i is a rise of sig[i]; bit WIDTH+i is a fall of sig[i].
- `covered_cnt`  out  CNT_W  population count of the sticky mask.
- `all_covered`  out  1  high when covered_cnt == 2*WIDTH.

## Operation
- Two-state FSM: INIT (no valid previous sample) and TRACK.
- Reset sets state=INIT, prev=0, seen=0, valid=0, covered_cnt=0, all_covered=0.
- INIT, en=1: prev<=sig, go to TRACK, valid<=0. This is the priming sample; it never reports toggles.
- INIT, en=0: hold state, valid<=0.
- TRACK, en=1, event computation:
  - rise = ~prev & sig
  - fall = prev & ~sig
  - hits = {fall, rise}
  - prev<=sig
- TRACK, en=0: hits=0, prev held.
  - Changes on `sig` while en is low are invisible.
  - The next enabled sample is compared against the last enabled sample.
- Sticky mask update: seen <= (clear ? 0 : seen) | hits.
  - `clear` in the same cycle as a hit leaves exactly that cycle's hits set.
- `covered_cnt` <= popcount of the next value of `seen`; registered.
- `all_covered` <= (next covered_cnt == 2*WIDTH); registered.
- `valid` <= report mask, registered. The report mask is defined in Configuration.
- `clear` does not affect state, `prev` or the INIT/TRACK transition.
- Reset mid-operation returns the block to INIT. The first enabled sample after reset re-primes and reports nothing.
- Counter arithmetic: unsigned, no wrap possible because 2^CNT_W > 2*WIDTH.

## Timing
- Latency: an enabled sample at cycle N drives `valid`, `covered_cnt` and `all_covered` on cycle N+1, all updating on the same edge.
- `valid` is a one-cycle pulse. It is 0 on any cycle following en=0, the INIT state, or reset.
- Back-to-back toggles on consecutive enabled cycles give consecutive `valid` pulses. There are no bubbles.
- `clear` at cycle N gives covered_cnt = popcount(hits at N) on cycle N+1.
- No handshake or backpressure: the downstream reporter consumes `valid` every cycle.

## Configuration
- `TOGGLE_FIRST_HIT_EN` defined: report mask = hits & ~(clear ? 0 : seen). Each event is reported only on its first occurrence since reset or the last `clear`, which limits reporter call volume.
- `TOGGLE_FIRST_HIT_EN` not defined: report mask = hits. Every occurrence is reported.
- `seen`, `covered_cnt` and `all_covered` behave identically in both builds.

## Test plan
All scenarios use WIDTH=16.
1. Priming: reset, then en=1 with sig=0xFFFF → next cycle valid=0x00000000 and covered_cnt=0. A following en=1 with sig=0xFFFF → valid=0.
2. Rise and fall: sig 0x0000 (primed), then 0x0001 → valid=0x00000001. Then 0x0000 → valid=0x00010000. covered_cnt=2.
3. Enable gating: primed with 0x0000, then en=0 while sig goes 0x00FF→0x0F0F→0x00FF. Then en=1 with 0x00FF → valid=0x000000FF. All cycles with en=0 give valid=0.
4. First-hit mode: bit0 rises twice (0→1→0→1).
   - With TOGGLE_FIRST_HIT_EN: second rise gives valid=0x00000000.
   - Without it: valid=0x00000001.
   - covered_cnt=2 in both builds.
5. Full coverage and clear:
   - sig 0x0000→0xFFFF→0x0000 → covered_cnt=32, all_covered=1.
   - Assert clear together with a 0x0000→0x0003 change → next cycle covered_cnt=2, all_covered=0.
   - With the macro defined, valid=0x00000003 on that cycle.
6. Reset mid-operation: with covered_cnt=5, pulse reset → all outputs 0. Then en=1 with sig=0xA5A5 → valid=0 (re-prime). Then 0xA5A4 → valid=0x00010000.
